// File: rtl/multu_seq.sv
// Iterative unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product into hi/lo.
// Latency: result and done pulse exactly WIDTH cycles after the accepting start edge.
// Backpressure: none; start is always accepted and aborts any operation in flight.
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] mq_nxt;
    logic             last;

    // acc[WIDTH] is always zero between iterations, so adding the full acc is
    // equivalent to adding its low WIDTH bits; the carry lands in sum[WIDTH].
    always_comb begin
        sum     = acc + (mq[0] ? {1'b0, mcand} : '0);
        acc_nxt = {1'b0, sum[WIDTH:1]};
        mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        last    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand <= multiplicand;
                mq    <= multiplier;
                acc   <= '0;
                count <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                acc   <= acc_nxt;
                mq    <= mq_nxt;
                count <= count + CW'(1);
                // hi/lo only ever see the finished product
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    hi   <= acc_nxt[WIDTH-1:0];
                    lo   <= mq_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq: directed cases plus randomized operands and restarts.
module tb_multu_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    always #5 clock = ~clock;

    multu_seq #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    int          checks = 0;
    int          passes = 0;
    logic [63:0] exp_q[$];

    // Reference: an operation is a product that becomes visible W cycles after start
    bit          m_active = 0;
    int          m_rem    = 0;
    logic [63:0] m_prod   = '0;
    logic [63:0] m_hilo   = '0;
    bit          m_done   = 0;
    bit          mon_en   = 0;
    bit          run_mon  = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic cycle(input bit r, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        reset        = r;
        start        = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        m_done = 0;
        if (r) begin
            m_active = 0;
            m_hilo   = '0;
        end else if (s) begin
            m_active = 1;
            m_rem    = W;
            m_prod   = {32'b0, a} * {32'b0, b};
        end else if (m_active) begin
            m_rem--;
            if (m_rem == 0) begin
                m_active = 0;
                m_hilo   = m_prod;
                m_done   = 1;
                exp_q.push_back(m_prod);
            end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, $urandom, $urandom);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] expected, input string name);
        cycle(0, 1, a, b);
        idle(W);
        check({name, "_done"}, done, 1);
        check(name, {hi, lo}, expected);
    endtask

    // Monitor: per-cycle comparison with the model, products popped on done
    initial begin
        bit prev_done = 0;
        while (run_mon) begin
            @(negedge clock);
            if (!run_mon) break;
            if (mon_en) begin
                check("busy", busy, m_active);
                check("done", done, m_done);
                check("hilo", {hi, lo}, m_hilo);
                if (done) begin
                    check("done_width", prev_done, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL scoreboard: done with empty queue, hilo=%h", {hi, lo});
                    end else begin
                        check("product", {hi, lo}, exp_q.pop_front());
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        int gap;
        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;

        // 1: reset then idle
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        mon_en = 1;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        idle(5);
        check("idle_hilo", {hi, lo}, 64'h0);
        check("idle_busy", busy, 0);

        // 2: 3 x 5, latency check
        cycle(0, 1, 3, 5);
        check("t2_busy_start", busy, 1);
        idle(W - 1);
        check("t2_busy_late", busy, 1);
        check("t2_no_early_done", done, 0);
        idle(1);
        check("t2_done", done, 1);
        check("t2_prod", {hi, lo}, 64'h0000_0000_0000_000F);
        idle(1);
        check("t2_done_fall", done, 0);

        // 3: corner operands
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "t3_ones");
        op(32'h8000_0000, 32'h2, 64'h0000_0001_0000_0000, "t3_msb");

        // 4: zero operand, full latency, prior result holds
        cycle(0, 1, 0, 32'hDEAD_BEEF);
        idle(W - 1);
        check("t4_hold", {hi, lo}, 64'h0000_0001_0000_0000);
        check("t4_no_early_done", done, 0);
        idle(1);
        check("t4_done", done, 1);
        check("t4_prod", {hi, lo}, 64'h0);

        // 5: restart at cycle 10
        cycle(0, 1, 7, 9);
        idle(9);
        cycle(0, 1, 32'h1_0000, 32'h1_0000);
        idle(W - 1);
        check("t5_no_done", done, 0);
        idle(1);
        check("t5_done", done, 1);
        check("t5_prod", {hi, lo}, 64'h0000_0001_0000_0000);

        // 6: reset mid-op, then start in a done cycle
        cycle(0, 1, 11, 13);
        idle(19);
        cycle(1, 0, 0, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_hilo", {hi, lo}, 64'h0);
        check("t6_rst_done", done, 0);
        op(2, 3, 64'd6, "t6_first");
        cycle(0, 1, 6, 7);
        check("t6_busy", busy, 1);
        check("t6_done_fall", done, 0);
        idle(W);
        check("t6_prod", {hi, lo}, 64'd42);

        // Random operands, spacing, restarts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: a = '0;
                1: a = '1;
                2: b = '1;
                default: ;
            endcase
            cycle(0, 1, a, b);
            if ($urandom_range(0, 3) == 0) gap = $urandom_range(0, W - 1);
            else gap = W + $urandom_range(0, 4);
            idle(gap);
            if ($urandom_range(0, 99) == 0) cycle(1, 0, 0, 0);
        end

        idle(W + 8);
        check("queue_empty", exp_q.size(), 0);
        run_mon = 0;
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
